layer_sequencer: RTL

Parametrised top-level sequencer for the MobileNet accelerator: runs one frame through camera capture and then walks a configurable number of layers, each as a fetch → compute → write-back sequence, with global average pooling on the last layer. It replaces the fixed master control FSM. New features over that FSM:

- explicit frame start/done handshake;
- continuous mode;
- per-stage watchdog with error reporting;
- synchronous abort.

---
 rtl/layer_seq_pkg.sv | 21 ++
 rtl/layer_sequencer_watchdog.sv | 39 +++
 rtl/layer_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/layer_seq_pkg.sv
// Shared constants for the MobileNet layer sequencer: state/stage encodings and default sizing.
// Stage states double as the error stage code reported when the watchdog fires.
package layer_seq_pkg;

  localparam int DEF_NUM_LAYERS = 38;
  localparam int DEF_OPCODE_W   = 6;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CAM   = 3'd1;
  localparam state_t S_FETCH = 3'd2;
  localparam state_t S_CONV  = 3'd3;
  localparam state_t S_AVE   = 3'd4;
  localparam state_t S_WB    = 3'd5;
  localparam state_t S_DONE  = 3'd6;
  localparam state_t S_ERROR = 3'd7;

  localparam logic [2:0] STAGE_NONE = 3'd0;

endpackage

// File: rtl/layer_sequencer_watchdog.sv
// Per-stage watchdog: a clearable, saturating wait counter that flags the cycle
// whose increment would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module seq_watchdog #(
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                   WD_ON = (TIMEOUT_CYCLES != 0);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Deliberately independent of clear_i so the FSM can derive clear from its next state.
  assign timeout_o = WD_ON && enable_i && (count_q == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Frame sequencer: camera capture, then fetch/compute/write-back per layer, with
// average pooling on the last layer, continuous mode, watchdog errors and abort.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS     = DEF_NUM_LAYERS,
  parameter int OPCODE_W       = DEF_OPCODE_W,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_continuous,
  input  logic                i_abort,
  input  logic                i_clear_err,
  input  logic                i_finish_cam,
  input  logic                i_finish_fet,
  input  logic                i_finish_conv,
  input  logic                i_finish_writeBack,
  input  logic                i_finish_ave,
  output logic                o_startCam,
  output logic                o_startFet,
  output logic                o_startConvolution,
  output logic                o_startAve,
  output logic                o_startWriteBack,
  output logic                o_wrActiveCam,
  output logic                o_opConv,
  output logic [OPCODE_W-1:0] o_opcode,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [2:0]          o_err_stage
);

  localparam logic [OPCODE_W-1:0] LAST_OP = OPCODE_W'(NUM_LAYERS - 1);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [2:0]          err_stage_q, err_stage_d;
  logic                first_q;
  logic                waiting;
  logic                stage_fin;
  logic                finish_ok;
  logic                timeout;

  assign waiting = (state_q >= S_CAM) && (state_q <= S_WB);

  always_comb begin
    stage_fin = 1'b0;
    case (state_q)
      S_CAM:   stage_fin = i_finish_cam;
      S_FETCH: stage_fin = i_finish_fet;
      S_CONV:  stage_fin = i_finish_conv;
      S_AVE:   stage_fin = i_finish_ave;
      S_WB:    stage_fin = i_finish_writeBack;
      default: stage_fin = 1'b0;
    endcase
  end

  // The start-pulse cycle never accepts a finish, so engines get one clean cycle to react.
  assign finish_ok = stage_fin && !first_q;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    err_stage_d = err_stage_q;
    if (i_abort && (state_q != S_ERROR)) begin
      state_d  = S_IDLE;
      opcode_d = '0;
    end else if (waiting) begin
      if (finish_ok) begin
        case (state_q)
          S_CAM:   state_d = S_FETCH;
          S_FETCH: state_d = (opcode_q == LAST_OP) ? S_AVE : S_CONV;
          S_CONV,
          S_AVE:   state_d = S_WB;
          S_WB: begin
            if (opcode_q < LAST_OP) begin
              opcode_d = opcode_q + 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
          default: state_d = state_q;
        endcase
      end else if (timeout) begin
        state_d     = S_ERROR;
        err_stage_d = state_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d  = S_CAM;
            opcode_d = '0;
          end
        end
        S_DONE: begin
          state_d = i_continuous ? S_CAM : S_IDLE;
          if (i_continuous) begin
            opcode_d = '0;
          end
        end
        S_ERROR: begin
          if (i_clear_err) begin
            state_d     = S_IDLE;
            err_stage_d = STAGE_NONE;
            opcode_d    = '0;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      err_stage_q <= STAGE_NONE;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      err_stage_q <= err_stage_d;
      first_q     <= (state_d != state_q);
    end
  end

  seq_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear_i   (state_d != state_q),
    .enable_i  (waiting),
    .timeout_o (timeout)
  );

  assign o_startCam         = first_q && (state_q == S_CAM);
  assign o_startFet         = first_q && (state_q == S_FETCH);
  assign o_startConvolution = first_q && (state_q == S_CONV);
  assign o_startAve         = first_q && (state_q == S_AVE);
  assign o_startWriteBack   = first_q && (state_q == S_WB);
  assign o_wrActiveCam      = (state_q == S_CAM);
  assign o_opConv           = opcode_q[0];
  assign o_opcode           = opcode_q;
  assign o_busy             = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign o_done             = (state_q == S_DONE);
  assign o_error            = (state_q == S_ERROR);
  assign o_err_stage        = err_stage_q;

endmodule
